// File: rtl/activation_derivative_array_if.sv
`default_nettype none
// ============================================================================
// Module   : activation_derivative_array_if
// Brief    : Configuration, input-beat, output-beat and status signals of the
//            activation-derivative array, grouped for module ports.
// Revision : 1.0 - initial release
// ============================================================================
interface activation_derivative_array_if #(
  parameter int NUM_LANES = 4,
  parameter int WIDTH     = 16
);
  logic                       cfg_load;
  logic [1:0]                 cfg_mode;
  logic [WIDTH-1:0]           cfg_leak;
  logic                       in_valid;
  logic                       in_ready;
  logic [NUM_LANES*WIDTH-1:0] in_grad;
  logic [NUM_LANES*WIDTH-1:0] in_h;
  logic                       out_valid;
  logic                       out_ready;
  logic [NUM_LANES*WIDTH-1:0] out_data;
  logic                       sat_flag;
  logic                       sat_clr;

  // Driver side (gradient source, downstream sink, control)
  modport master (
    output cfg_load, cfg_mode, cfg_leak, in_valid, in_grad, in_h,
           out_ready, sat_clr,
    input  in_ready, out_valid, out_data, sat_flag
  );

  // Derivative unit side
  modport slave (
    input  cfg_load, cfg_mode, cfg_leak, in_valid, in_grad, in_h,
           out_ready, sat_clr,
    output in_ready, out_valid, out_data, sat_flag
  );
endinterface
`default_nettype wire

// File: rtl/activation_derivative_array.sv
`default_nettype none
// ============================================================================
// Module   : activation_derivative_array
// Brief    : Multi-lane, two-stage pipelined activation-derivative unit.
//            Gates each gradient lane by the sign of its forward
//            pre-activation (ReLU', LeakyReLU' or pass-through) under
//            valid/ready flow control, with a sticky saturation flag.
// Revision : 1.0 - initial release
// ============================================================================
module activation_derivative_array #(
  parameter int NUM_LANES = 4,
  parameter int WIDTH     = 16,
  parameter int FRAC      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  activation_derivative_array_if.slave  bus
);

  localparam int c_DW = NUM_LANES * WIDTH;
  localparam int c_PW = 2 * WIDTH;

  localparam logic [1:0] c_MODE_RELU  = 2'd0;
  localparam logic [1:0] c_MODE_LEAKY = 2'd1;

  localparam logic signed [WIDTH-1:0] c_ZERO = '0;
  localparam logic signed [c_PW-1:0]  c_HALF = c_PW'(1) << (FRAC - 1);
  localparam logic signed [c_PW-1:0]  c_MIN  = {c_PW{1'b1}} << (WIDTH - 1);
  localparam logic signed [c_PW-1:0]  c_MAX  = ~c_MIN;

  // Configuration registers
  logic [1:0]              r_cfg_mode;
  logic signed [WIDTH-1:0] r_cfg_leak;

  // Stage 1: raw operands, H sign, mode and full-width product
  logic                    r_s1_valid;
  logic [1:0]              r_s1_mode;
  logic [c_DW-1:0]         r_s1_grad;
  logic [NUM_LANES-1:0]    r_s1_hneg;
  logic [NUM_LANES*c_PW-1:0] r_s1_prod;

  // Stage 2: output register
  logic                    r_s2_valid;
  logic [c_DW-1:0]         r_out_data;
  logic                    r_sat;

  // Held low until the first clock after reset release
  logic                    r_rdy_en;

  logic                    w_s1_adv;
  logic                    w_in_ready;
  logic                    w_accept;
  logic signed [c_PW-1:0]  w_leak_e;
  logic [NUM_LANES*c_PW-1:0] w_prod;
  logic [NUM_LANES-1:0]    w_hneg;
  logic [c_DW-1:0]         w_s2_data;
  logic [NUM_LANES-1:0]    w_lane_sat;

  assign w_s1_adv   = !r_s2_valid || bus.out_ready;
  assign w_in_ready = r_rdy_en && (!r_s1_valid || w_s1_adv);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_leak_e   = {{WIDTH{r_cfg_leak[WIDTH-1]}}, r_cfg_leak};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic signed [WIDTH-1:0] w_in_g;
    logic signed [WIDTH-1:0] w_in_h;
    logic signed [c_PW-1:0]  w_in_ge;
    logic signed [WIDTH-1:0] w_s1_g;
    logic signed [c_PW-1:0]  w_s1_p;
    logic signed [c_PW-1:0]  w_rnd;
    logic                    w_hi;
    logic                    w_lo;
    logic                    w_neg;
    logic [WIDTH-1:0]        w_scaled;

    // Stage-1 inputs: sign-extended product and H sign (zero is non-negative)
    assign w_in_g  = bus.in_grad[i*WIDTH +: WIDTH];
    assign w_in_h  = bus.in_h[i*WIDTH +: WIDTH];
    assign w_in_ge = {{WIDTH{w_in_g[WIDTH-1]}}, w_in_g};
    assign w_prod[i*c_PW +: c_PW] = w_in_ge * w_leak_e;
    assign w_hneg[i] = (w_in_h < c_ZERO);

    // Stage-2 datapath: round half up, arithmetic shift, clamp
    assign w_s1_g   = r_s1_grad[i*WIDTH +: WIDTH];
    assign w_s1_p   = r_s1_prod[i*c_PW +: c_PW];
    assign w_rnd    = (w_s1_p + c_HALF) >>> FRAC;
    assign w_hi     = (w_rnd > c_MAX);
    assign w_lo     = (w_rnd < c_MIN);
    assign w_scaled = w_hi ? c_MAX[WIDTH-1:0] :
                      w_lo ? c_MIN[WIDTH-1:0] : w_rnd[WIDTH-1:0];
    assign w_neg    = r_s1_hneg[i];

    assign w_s2_data[i*WIDTH +: WIDTH] =
        (r_s1_mode == c_MODE_RELU  && w_neg) ? '0       :
        (r_s1_mode == c_MODE_LEAKY && w_neg) ? w_scaled : w_s1_g;

    // A clamp only matters when the scaled value is the lane's result
    assign w_lane_sat[i] = (r_s1_mode == c_MODE_LEAKY) && w_neg && (w_hi || w_lo);
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_data  = r_out_data;
  assign bus.sat_flag  = r_sat;

  // Ready enable and configuration capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdy_en   <= 1'b0;
      r_cfg_mode <= c_MODE_RELU;
      r_cfg_leak <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (bus.cfg_load) begin
        r_cfg_mode <= bus.cfg_mode;
        r_cfg_leak <= bus.cfg_leak;
      end
    end
  end

  // Stage 1: loads when empty or when its content moves on to stage 2
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= c_MODE_RELU;
      r_s1_grad  <= '0;
      r_s1_hneg  <= '0;
      r_s1_prod  <= '0;
    end else if (w_s1_adv || !r_s1_valid) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_mode <= r_cfg_mode;
        r_s1_grad <= bus.in_grad;
        r_s1_hneg <= w_hneg;
        r_s1_prod <= w_prod;
      end
    end
  end

  // Stage 2: output register, held while downstream stalls; bubbles write zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_out_data <= '0;
    end else if (w_s1_adv) begin
      r_s2_valid <= r_s1_valid;
      r_out_data <= r_s1_valid ? w_s2_data : '0;
    end
  end

  // Sticky saturation flag; a new saturation wins over a clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sat <= 1'b0;
    end else if (w_s1_adv && r_s1_valid && (|w_lane_sat)) begin
      r_sat <= 1'b1;
    end else if (bus.sat_clr) begin
      r_sat <= 1'b0;
    end
  end

endmodule
`default_nettype wire
